fp_norm_decoder: RTL and testbench

- Decode side of the leading-one priority encoder used in the floating-point multiplier datapath.
- Takes an unnormalized 23-bit mantissa plus its encoded leading-one position (5-bit index and nonzero flag).
- Decodes the index to a one-hot mask and a shift amount, then normalizes: shifts the mantissa so its leading one sits at bit 22 and adjusts the exponent.
- Two-stage elastic pipeline with valid/ready handshake on both sides; sits between product-mantissa encode and result packing.

---
 rtl/fp_norm_decoder.sv | 144 ++++++++++++++
 tb/tb_fp_norm_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_decoder.sv
// fp_norm_decoder: decodes an encoded leading-one position into a one-hot mask
// and a shift amount, then normalizes mantissa/exponent so the leading one lands
// at bit MW-1. Two-stage elastic pipeline with valid/ready on both sides.
module fp_norm_decoder #(
  parameter int MW = 23,
  parameter int PW = 5,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_pos,
  input  logic          in_nz,
  input  logic [MW-1:0] in_mant,
  input  logic [EW-1:0] in_exp,
  input  logic          in_sign,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] out_mant,
  output logic [EW-1:0] out_exp,
  output logic          out_sign,
  output logic [MW-1:0] out_onehot,
  output logic          out_zero,
  output logic          out_uf,
  output logic          out_err
);

  // Decoded beat held between the two stages.
  typedef struct packed {
    logic [MW-1:0] onehot;
    logic [PW-1:0] shift;
    logic          err;
    logic          zero;
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    logic          sign;
  } dec_t;

  // Normalized result beat presented on the output port.
  typedef struct packed {
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    logic          sign;
    logic [MW-1:0] onehot;
    logic          zero;
    logic          uf;
    logic          err;
  } res_t;

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  dec_t s1_q, s1_d, dec;
  res_t s2_q, s2_d, norm;
  logic s1_load, s2_load;

  // Stage 2 frees up when empty or draining; stage 1 frees up when empty or
  // moving into stage 2. Neither depends on in_valid.
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // Stage 1 decode: one-hot mask, shift distance and consistency check.
  always_comb begin
    logic          in_range;
    logic [PW:0]   pos_p1;
    // NOTE: every variable gets a default first so no latch is inferred.
    dec      = '0;
    in_range = (in_pos <= PW'(MW - 1));
    pos_p1   = {1'b0, in_pos} + (PW+1)'(1);
    dec.onehot = (in_nz && in_range) ? (MW'(1) << in_pos) : '0;
    dec.shift  = PW'(MW - 1) - in_pos;
    if (in_nz) begin
      // Leading one must exist at in_pos with nothing set above it.
      dec.err = !in_range || ((in_mant & dec.onehot) == '0) ||
                ((in_mant >> pos_p1) != '0);
    end else begin
      dec.err = (in_mant != '0);
    end
    dec.zero = !in_nz;
    dec.mant = in_mant;
    dec.exp  = in_exp;
    dec.sign = in_sign;
  end

  // Stage 2 normalize with priority err > zero > underflow > normal.
  always_comb begin
    norm        = '0;
    norm.sign   = s1_q.sign;
    norm.onehot = s1_q.err ? '0 : s1_q.onehot;
    if (s1_q.err) begin
      norm.err = 1'b1;
    end else if (s1_q.zero) begin
      norm.zero = 1'b1;
    end else if (EW'(s1_q.shift) > s1_q.exp) begin
      norm.uf = 1'b1;
    end else begin
      norm.mant = s1_q.mant << s1_q.shift;
      norm.exp  = s1_q.exp - EW'(s1_q.shift);
    end
  end

  // Next-state for both pipeline registers; data only moves with a valid beat.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_d = dec;
    end
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_d = norm;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_mant   = s2_q.mant;
  assign out_exp    = s2_q.exp;
  assign out_sign   = s2_q.sign;
  assign out_onehot = s2_q.onehot;
  assign out_zero   = s2_q.zero;
  assign out_uf     = s2_q.uf;
  assign out_err    = s2_q.err;

endmodule

// File: tb/tb_fp_norm_decoder.sv
// Directed testbench for fp_norm_decoder.
module tb_fp_norm_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_pos;
  logic        in_nz;
  logic [22:0] in_mant;
  logic [7:0]  in_exp;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_sign;
  logic [22:0] out_onehot;
  logic        out_zero;
  logic        out_uf;
  logic        out_err;

  int n_cmp  = 0;
  int n_fail = 0;

  fp_norm_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pos(in_pos), .in_nz(in_nz), .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_sign(out_sign), .out_onehot(out_onehot),
    .out_zero(out_zero), .out_uf(out_uf), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] p, input logic nz,
                       input logic [22:0] m, input logic [7:0] e, input logic s);
    in_valid = v; in_pos = p; in_nz = nz; in_mant = m; in_exp = e; in_sign = s;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    drive(1'b1, 5'd10, 1'b1, 23'h000400, 8'd100, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if ({out_mant, out_exp, out_sign, out_onehot, out_zero, out_uf, out_err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: mant=%h exp=%0d onehot=%h flags=%b%b%b want all 0",
                         out_mant, out_exp, out_onehot, out_zero, out_uf, out_err);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  // One beat into an idle pipeline; result must appear exactly 2 cycles later.
  task automatic test_beat(input string name, input logic [4:0] p, input logic nz,
                           input logic [22:0] m, input logic [7:0] e, input logic s,
                           input logic [22:0] x_mant, input logic [7:0] x_exp,
                           input logic [22:0] x_onehot, input logic [2:0] x_flags);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(1'b1, p, nz, m, e, s);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s in_ready: got %b want 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s early_valid: got %b want 0", name, out_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s latency: out_valid %b want 1", name, out_valid);
    end
    n_cmp++;
    if (out_mant !== x_mant || out_exp !== x_exp || out_sign !== s ||
        out_onehot !== x_onehot || {out_zero, out_uf, out_err} !== x_flags) begin
      n_fail++;
      $display("FAIL %s result: mant=%h exp=%0d sign=%b onehot=%h zue=%b want mant=%h exp=%0d sign=%b onehot=%h zue=%b",
               name, out_mant, out_exp, out_sign, out_onehot, {out_zero, out_uf, out_err},
               x_mant, x_exp, s, x_onehot, x_flags);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  b_pos  [4] = '{5'd5, 5'd10, 5'd15, 5'd20};
    logic [22:0] b_mant [4] = '{23'h000021, 23'h000401, 23'h008001, 23'h100001};
    logic [22:0] x_mant [4] = '{23'h420000, 23'h401000, 23'h400080, 23'h400004};
    logic [7:0]  x_exp  [4] = '{8'd33, 8'd38, 8'd43, 8'd48};
    logic [22:0] x_oh   [4] = '{23'h000020, 23'h000400, 23'h008000, 23'h100000};
    int tx = 0, rx = 0;
    logic [22:0] held_mant = '0;
    logic [7:0]  held_exp = '0;
    for (int c = 0; c < 40 && rx < 4; c++) begin
      @(posedge clk); #1;
      out_ready = (c >= 4);
      if (tx < 4) drive(1'b1, b_pos[tx], 1'b1, b_mant[tx], 8'd50, tx[0]);
      else in_valid = 1'b0;
      #1;
      if (c == 2) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("FAIL b2b_backpressure: in_ready %b want 0 with 2 buffered", in_ready);
        end
        held_mant = out_mant; held_exp = out_exp;
      end
      if (c == 3) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_mant !== held_mant || out_exp !== held_exp) begin
          n_fail++; $display("FAIL b2b_hold: valid=%b mant=%h exp=%0d want valid=1 mant=%h exp=%0d",
                             out_valid, out_mant, out_exp, held_mant, held_exp);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_mant !== x_mant[rx] || out_exp !== x_exp[rx] || out_onehot !== x_oh[rx] ||
            out_sign !== rx[0] || {out_zero, out_uf, out_err} !== 3'b000) begin
          n_fail++; $display("FAIL b2b_beat%0d: mant=%h exp=%0d onehot=%h sign=%b want mant=%h exp=%0d onehot=%h sign=%b",
                             rx, out_mant, out_exp, out_onehot, out_sign, x_mant[rx], x_exp[rx], x_oh[rx], rx[0]);
        end
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (rx != 4) begin
      n_fail++; $display("FAIL b2b_count: received %0d beats want 4", rx);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_extra: out_valid %b want 0 after drain", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(1'b1, 5'd10, 1'b1, 23'h000400, 8'd100, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 5'd12, 1'b1, 23'h001000, 8'd90, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_mant !== '0) begin
      n_fail++; $display("FAIL midreset_clear: valid=%b mant=%h want 0/0", out_valid, out_mant);
    end
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
        n_fail++; $display("FAIL midreset_stale: %0d stale beats want 0", seen);
      end
    end
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    out_ready = 1'b1;
    test_reset();
    test_beat("normal_pos10", 5'd10, 1'b1, 23'h000400, 8'd100, 1'b1, 23'h400000, 8'd88, 23'h000400, 3'b000);
    test_beat("underflow",    5'd0,  1'b1, 23'h000001, 8'd5,   1'b0, 23'h000000, 8'd0,  23'h000001, 3'b010);
    test_beat("shift_eq_exp", 5'd0,  1'b1, 23'h000001, 8'd22,  1'b1, 23'h400000, 8'd0,  23'h000001, 3'b000);
    test_beat("pos22",        5'd22, 1'b1, 23'h400001, 8'd7,   1'b0, 23'h400001, 8'd7,  23'h400000, 3'b000);
    test_beat("zero",         5'd4,  1'b0, 23'h000000, 8'd50,  1'b1, 23'h000000, 8'd0,  23'h000000, 3'b100);
    test_beat("err_pos23",    5'd23, 1'b1, 23'h400000, 8'd50,  1'b1, 23'h000000, 8'd0,  23'h000000, 3'b001);
    test_beat("err_above",    5'd3,  1'b1, 23'h000010, 8'd50,  1'b0, 23'h000000, 8'd0,  23'h000000, 3'b001);
    test_beat("err_clear",    5'd3,  1'b1, 23'h000004, 8'd50,  1'b1, 23'h000000, 8'd0,  23'h000000, 3'b001);
    test_beat("err_nz0",      5'd0,  1'b0, 23'h000005, 8'd50,  1'b0, 23'h000000, 8'd0,  23'h000000, 3'b001);
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
